ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ram_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Word-organised RAM behind a valid/ready request/response handshake.
// Each access runs through a programmable wait phase before it completes.
module ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_be,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH)-1:0]   phy_addr
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic [BYTES-1:0]   r_be;
    logic               r_err;
    logic [3:0]         r_cnt;
    logic [IDX_W-1:0]   r_phyAddr;
    logic [DATA_W-1:0]  r_rspRdata;
    logic               r_rspErr;

    logic               w_idle;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_wordIdx;
    logic               w_misalign;
    logic               w_outOfRange;
    logic               w_reqErr;
    logic               w_enterResp;
    logic               w_accWe;
    logic [IDX_W-1:0]   w_accIdx;
    logic [DATA_W-1:0]  w_accWdata;
    logic [BYTES-1:0]   w_accBe;
    logic               w_accErr;
    logic               w_memWrite;

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = req_valid && w_idle;
    assign w_wordIdx    = req_addr >> OFF_W;
    assign w_misalign   = |(req_addr & ADDR_W'(BYTES - 1));
    assign w_outOfRange = ({1'b0, w_wordIdx} >= (ADDR_W + 1)'(DEPTH));
    assign w_reqErr     = w_misalign || w_outOfRange;

    // With WAIT=0 the access happens on the accept edge itself, so the live
    // request is used instead of the (not yet loaded) captured copy.
    assign w_accWe    = w_idle ? req_we                 : r_we;
    assign w_accIdx   = w_idle ? w_wordIdx[IDX_W-1:0]   : r_idx;
    assign w_accWdata = w_idle ? req_wdata              : r_wdata;
    assign w_accBe    = w_idle ? req_be                 : r_be;
    assign w_accErr   = w_idle ? w_reqErr               : r_err;

    assign w_enterResp = (w_accept && (WAIT == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_memWrite  = w_enterResp && w_accWe && !w_accErr && rst;

    assign req_ready = w_idle;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;
    assign phy_addr  = r_phyAddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_nextState = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_err      <= 1'b0;
            r_cnt      <= 4'd0;
            r_phyAddr  <= '0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we      <= req_we;
                r_idx     <= w_wordIdx[IDX_W-1:0];
                r_wdata   <= req_wdata;
                r_be      <= req_be;
                r_err     <= w_reqErr;
                r_cnt     <= 4'(WAIT);
                r_phyAddr <= w_wordIdx[IDX_W-1:0];
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_phyAddr <= '0;
            end
            if (w_enterResp) begin
                r_rspErr   <= w_accErr;
                r_rspRdata <= (w_accErr || w_accWe) ? '0 : r_mem[w_accIdx];
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_memWrite) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_accBe[b]) begin
                    r_mem[w_accIdx][b*8 +: 8] <= w_accWdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a WAIT=2 instance for the main scenarios
// and a WAIT=0 instance for back-to-back throughput.
module tb_ram_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [9:0]  phy;
    } respExp_t;

    logic        clk;
    logic        rstN;

    logic        reqValid, reqReady, reqWe, rspValid, rspReady, rspErr;
    logic [31:0] reqAddr, reqWdata, rspRdata;
    logic [3:0]  reqBe;
    logic [9:0]  phyAddr;

    logic        reqValidZ, reqReadyZ, reqWeZ, rspValidZ, rspReadyZ, rspErrZ;
    logic [31:0] reqAddrZ, reqWdataZ, rspRdataZ;
    logic [3:0]  reqBeZ;
    logic [9:0]  phyAddrZ;

    int          compared   = 0;
    int          mismatched = 0;
    respExp_t    sb[$];
    logic [31:0] model [int];

    ram_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT(2)) dut (
        .clk(clk), .rst(rstN),
        .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata),
        .rsp_err(rspErr), .phy_addr(phyAddr)
    );

    ram_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT(0)) dutZ (
        .clk(clk), .rst(rstN),
        .req_valid(reqValidZ), .req_ready(reqReadyZ), .req_we(reqWeZ),
        .req_addr(reqAddrZ), .req_wdata(reqWdataZ), .req_be(reqBeZ),
        .rsp_valid(rspValidZ), .rsp_ready(rspReadyZ), .rsp_rdata(rspRdataZ),
        .rsp_err(rspErrZ), .phy_addr(phyAddrZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Independent reference: error when unaligned or beyond the 4 KiB window.
    function automatic respExp_t predict(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         input bit commit);
        respExp_t    e;
        logic [31:0] cur;
        int          idx;
        idx     = int'(addr >> 2);
        e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
        e.phy   = addr[11:2];
        e.rdata = 32'h0;
        if (!e.err) begin
            cur = model.exists(idx) ? model[idx] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
                end
                if (commit) model[idx] = cur;
            end else begin
                e.rdata = cur;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input bit commit);
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(reqReady), 32'd1);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wdata;
        reqBe    = be;
        sb.push_back(predict(we, addr, wdata, be, commit));
    endtask

    task automatic collectResponse(input int expLat, input int holdCycles);
        int       n;
        respExp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) reqValid = 1'b0;
        end while (!rspValid && n < 20);
        checkOutput("latency", 32'(n), 32'(expLat));
        if (sb.size() == 0) begin
            checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput("rsp_rdata", rspRdata, e.rdata);
        checkOutput("rsp_err", 32'(rspErr), 32'(e.err));
        checkOutput("phy_addr", 32'(phyAddr), 32'(e.phy));
        checkOutput("req_ready_busy", 32'(reqReady), 32'd0);
        for (int h = 0; h < holdCycles; h++) begin
            reqValid = 1'b1;
            reqWe    = 1'b1;
            reqAddr  = 32'h30;
            reqWdata = 32'hFFFF_FFFF;
            reqBe    = 4'hF;
            @(negedge clk);
            checkOutput("hold_valid", 32'(rspValid), 32'd1);
            checkOutput("hold_rdata", rspRdata, e.rdata);
            checkOutput("hold_err", 32'(rspErr), 32'(e.err));
            checkOutput("hold_req_ready", 32'(reqReady), 32'd0);
        end
        reqValid  = 1'b0;
        rspReady  = 1'b1;
        @(negedge clk);
        rspReady  = 1'b0;
        checkOutput("post_hs_valid", 32'(rspValid), 32'd0);
        checkOutput("post_hs_ready", 32'(reqReady), 32'd1);
        checkOutput("post_hs_phy", 32'(phyAddr), 32'd0);
    endtask

    initial begin
        logic        weT   [6];
        logic [31:0] addrT [6];
        logic [31:0] dataT [6];
        logic [3:0]  beT   [6];
        int          next;
        respExp_t    e;

        rstN = 1'b0;
        {reqValid, reqWe, reqAddr, reqWdata, reqBe, rspReady} = '0;
        {reqValidZ, reqWeZ, reqAddrZ, reqWdataZ, reqBeZ, rspReadyZ} = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_rsp_rdata", rspRdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
        checkOutput("rst_phy_addr", 32'(phyAddr), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(reqReady), 32'd1);

        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1); collectResponse(3, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);         collectResponse(3, 0);
        applyStimulus(1'b1, 32'h10, 32'h0000_00AA, 4'h1, 1'b1); collectResponse(3, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);         collectResponse(3, 0);

        applyStimulus(1'b0, 32'h11, 32'h0, 4'hF, 1'b1);           collectResponse(3, 0);
        applyStimulus(1'b0, 32'h1000, 32'h0, 4'hF, 1'b1);         collectResponse(3, 0);
        applyStimulus(1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 1'b1);   collectResponse(3, 0);
        applyStimulus(1'b1, 32'h10, 32'h0000_0000, 4'h0, 1'b1);   collectResponse(3, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);           collectResponse(3, 0);

        applyStimulus(1'b1, 32'h30, 32'h55AA_55AA, 4'hF, 1'b1); collectResponse(3, 0);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 1'b1);         collectResponse(3, 5);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 1'b1);         collectResponse(3, 0);

        // Reset lands while the write is still waiting, so it must not commit.
        applyStimulus(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b1); collectResponse(3, 0);
        applyStimulus(1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0);
        @(negedge clk);
        reqValid = 1'b0;
        rstN     = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("midrst_rsp_rdata", rspRdata, 32'd0);
        checkOutput("midrst_rsp_err", 32'(rspErr), 32'd0);
        checkOutput("midrst_phy_addr", 32'(phyAddr), 32'd0);
        checkOutput("midrst_req_ready", 32'(reqReady), 32'd1);
        void'(sb.pop_front());
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 1'b1); collectResponse(3, 0);

        weT   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        addrT = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h40};
        dataT = '{32'h1111_2222, 32'h3333_4444, 32'h0, 32'h0, 32'h0000_9900, 32'h0};
        beT   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h2, 4'hF};
        @(negedge clk);
        rspReadyZ = 1'b1;
        reqValidZ = 1'b1;
        reqWeZ = weT[0]; reqAddrZ = addrT[0]; reqWdataZ = dataT[0]; reqBeZ = beT[0];
        sb.push_back(predict(weT[0], addrT[0], dataT[0], beT[0], 1'b1));
        next = 1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            checkOutput("z_rsp_valid_phase", 32'(rspValidZ), 32'(j % 2));
            checkOutput("z_req_ready_phase", 32'(reqReadyZ), 32'((j + 1) % 2));
            if ((j % 2) == 1) begin
                if (rspValidZ && sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("z_rsp_rdata", rspRdataZ, e.rdata);
                    checkOutput("z_rsp_err", 32'(rspErrZ), 32'(e.err));
                end
                if (next < 6) begin
                    reqWeZ = weT[next]; reqAddrZ = addrT[next];
                    reqWdataZ = dataT[next]; reqBeZ = beT[next];
                    sb.push_back(predict(weT[next], addrT[next], dataT[next], beT[next], 1'b1));
                    next++;
                end else begin
                    reqValidZ = 1'b0;
                end
            end
        end
        checkOutput("z_scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
